// File: rtl/updown_counter_param.sv
`default_nettype none
// ============================================================================
// Module   : updown_counter_param
// Purpose  : Parametrised up/down counter with modulus, wrap/saturate, load,
//            terminal-count pulse and sticky overflow/underflow flags.
// Revision : 1.0
// ============================================================================
module updown_counter_param #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_VAL   = (2**WIDTH) - 1,
  parameter bit          SATURATE  = 1'b0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] c_max   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] c_reset = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] c_zero  = '0;
  localparam logic [WIDTH-1:0] c_one   = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_load_sat;
  logic             w_at_max;
  logic             w_at_min;
  logic             w_step;
  logic             w_ovf_evt;
  logic             w_unf_evt;

  assign w_at_max  = (r_count == c_max);
  assign w_at_min  = (r_count == c_zero);
  assign w_step    = en & ~load;
  assign w_ovf_evt = w_step &  up_down & w_at_max;
  assign w_unf_evt = w_step & ~up_down & w_at_min;

  // A full-range modulus cannot be exceeded by load_val, so no clamp is built.
  generate
    if (MAX_VAL == (2**WIDTH) - 1) begin : g_full_range
      assign w_load_sat = load_val;
    end else begin : g_clamp
      assign w_load_sat = (load_val > c_max) ? c_max : load_val;
    end
  endgenerate

  always_comb begin
    w_count_nxt = r_count;
    if (load) begin
      w_count_nxt = w_load_sat;
    end else if (en) begin
      if (up_down) begin
        if (!w_at_max) begin
          w_count_nxt = r_count + c_one;
        end else if (!SATURATE) begin
          w_count_nxt = c_zero;
        end
      end else begin
        if (!w_at_min) begin
          w_count_nxt = r_count - c_one;
        end else if (!SATURATE) begin
          w_count_nxt = c_max;
        end
      end
    end
  end

  // A flag set-event on the same edge as clr_flags leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= c_reset;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_tc    <= w_ovf_evt | w_unf_evt;
      r_ovf   <= w_ovf_evt | (r_ovf & ~clr_flags);
      r_unf   <= w_unf_evt | (r_unf & ~clr_flags);
    end
  end

  assign count  = r_count;
  assign tc     = r_tc;
  assign at_max = w_at_max;
  assign at_min = w_at_min;
  assign ovf    = r_ovf;
  assign unf    = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_param.sv
`default_nettype none
// Bench for updown_counter_param: unit A wraps at 15 from reset 0, unit B
// saturates at 9 from reset 5.
module tb_updown_counter_param;

  typedef struct {
    int         sel;
    logic       rst;
    logic       en;
    logic       ud;
    logic       ld;
    logic [3:0] lv;
    logic       clr;
    logic [3:0] cnt;
    logic       tc;
    logic       ovf;
    logic       unf;
  } vec_t;

  typedef struct {
    int         sel;
    logic [3:0] cnt;
    logic       tc;
    logic       ovf;
    logic       unf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst = 1'b1, a_en = 1'b0, a_ud = 1'b0, a_ld = 1'b0, a_clr = 1'b0;
  logic [3:0] a_lv = 4'd0;
  logic [3:0] a_count;
  logic       a_tc, a_at_max, a_at_min, a_ovf, a_unf;

  logic       b_rst = 1'b1, b_en = 1'b0, b_ud = 1'b0, b_ld = 1'b0, b_clr = 1'b0;
  logic [3:0] b_lv = 4'd0;
  logic [3:0] b_count;
  logic       b_tc, b_at_max, b_at_min, b_ovf, b_unf;

  updown_counter_param #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1'b0), .RESET_VAL(0)) u_a (
    .clk(clk), .rst(a_rst), .en(a_en), .up_down(a_ud), .load(a_ld), .load_val(a_lv),
    .clr_flags(a_clr), .count(a_count), .tc(a_tc), .at_max(a_at_max), .at_min(a_at_min),
    .ovf(a_ovf), .unf(a_unf));

  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1), .RESET_VAL(5)) u_b (
    .clk(clk), .rst(b_rst), .en(b_en), .up_down(b_ud), .load(b_ld), .load_val(b_lv),
    .clr_flags(b_clr), .count(b_count), .tc(b_tc), .at_max(b_at_max), .at_min(b_at_min),
    .ovf(b_ovf), .unf(b_unf));

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  vec_t tbl[$];

  int   m_cnt[2];
  bit   m_ovf[2];
  bit   m_unf[2];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle on the selected unit, queue its expectation, then score it.
  task automatic drive(input int s, input logic r, input logic e, input logic u,
                       input logic l, input logic [3:0] lv, input logic c,
                       input logic [3:0] ec, input logic etc, input logic eo,
                       input logic eu);
    exp_t x;
    int   top;
    @(negedge clk);
    a_rst = 1'b0; a_en = 1'b0; a_ud = 1'b0; a_ld = 1'b0; a_lv = 4'd0; a_clr = 1'b0;
    b_rst = 1'b0; b_en = 1'b0; b_ud = 1'b0; b_ld = 1'b0; b_lv = 4'd0; b_clr = 1'b0;
    if (s == 0) begin
      a_rst = r; a_en = e; a_ud = u; a_ld = l; a_lv = lv; a_clr = c;
    end else begin
      b_rst = r; b_en = e; b_ud = u; b_ld = l; b_lv = lv; b_clr = c;
    end
    sb.push_back('{s, ec, etc, eo, eu});
    @(posedge clk);
    #1;
    x   = sb.pop_front();
    top = (x.sel == 0) ? 15 : 9;
    if (x.sel == 0) begin
      check("a.count",  int'(a_count),  int'(x.cnt));
      check("a.tc",     int'(a_tc),     int'(x.tc));
      check("a.ovf",    int'(a_ovf),    int'(x.ovf));
      check("a.unf",    int'(a_unf),    int'(x.unf));
      check("a.at_max", int'(a_at_max), int'(x.cnt) == top);
      check("a.at_min", int'(a_at_min), int'(x.cnt) == 0);
    end else begin
      check("b.count",  int'(b_count),  int'(x.cnt));
      check("b.tc",     int'(b_tc),     int'(x.tc));
      check("b.ovf",    int'(b_ovf),    int'(x.ovf));
      check("b.unf",    int'(b_unf),    int'(x.unf));
      check("b.at_max", int'(b_at_max), int'(x.cnt) == top);
      check("b.at_min", int'(b_at_min), int'(x.cnt) == 0);
    end
  endtask

  // Behavioural reference: computes the expected result and drives the cycle.
  task automatic model_step(input int s, input logic r, input logic e, input logic u,
                            input logic l, input logic [3:0] lv, input logic c);
    int mx  = (s == 0) ? 15 : 9;
    bit sat = (s == 1);
    int rv  = (s == 0) ? 0 : 5;
    int nc  = m_cnt[s];
    bit no  = m_ovf[s];
    bit nu  = m_unf[s];
    bit oev = 1'b0;
    bit uev = 1'b0;
    if (r) begin
      nc = rv; no = 1'b0; nu = 1'b0;
    end else begin
      if (l) begin
        nc = (int'(lv) > mx) ? mx : int'(lv);
      end else if (e && u) begin
        if (nc == mx) begin oev = 1'b1; nc = sat ? mx : 0; end
        else nc = nc + 1;
      end else if (e) begin
        if (nc == 0) begin uev = 1'b1; nc = sat ? 0 : mx; end
        else nc = nc - 1;
      end
      if (c) begin no = 1'b0; nu = 1'b0; end
      if (oev) no = 1'b1;
      if (uev) nu = 1'b1;
    end
    m_cnt[s] = nc; m_ovf[s] = no; m_unf[s] = nu;
    drive(s, r, e, u, l, lv, c, 4'(nc), oev | uev, no, nu);
  endtask

  function automatic vec_t v(input int s, input logic r, input logic e, input logic u,
                             input logic l, input logic [3:0] lv, input logic c,
                             input logic [3:0] ec, input logic etc, input logic eo,
                             input logic eu);
    vec_t t;
    t = '{s, r, e, u, l, lv, c, ec, etc, eo, eu};
    return t;
  endfunction

  initial begin
    // sel rst en ud ld lv clr | count tc ovf unf
    tbl.push_back(v(0, 0, 0, 0, 1, 4'd15, 0, 4'd15, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 1, 0, 4'd0,  1, 4'd0,  1, 1, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 4'd0,  0, 4'd0,  0, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 4'd7,  0, 4'd7,  0, 1, 0));
    tbl.push_back(v(1, 1, 1, 1, 1, 4'd2,  0, 4'd5,  0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 1, 4'd12, 0, 4'd9,  0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(v(1, 0, 1, 1, 0, 4'd0, 0, 4'd9, 1, 1, 0));
    for (int i = 8; i >= 0; i--) tbl.push_back(v(1, 0, 1, 0, 0, 4'd0, 0, 4'(i), 0, 1, 0));
    tbl.push_back(v(1, 0, 1, 0, 0, 4'd0,  0, 4'd0,  1, 1, 1));
    tbl.push_back(v(1, 0, 1, 0, 0, 4'd0,  0, 4'd0,  1, 1, 1));
    tbl.push_back(v(1, 0, 0, 0, 1, 4'd5,  0, 4'd5,  0, 1, 1));
    tbl.push_back(v(1, 0, 1, 1, 1, 4'd2,  0, 4'd2,  0, 1, 1));
    tbl.push_back(v(1, 1, 0, 0, 1, 4'd7,  0, 4'd5,  0, 0, 0));
    tbl.push_back(v(1, 0, 1, 1, 0, 4'd0,  0, 4'd6,  0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 1, 4'd15, 0, 4'd9,  0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 1, 4'd0,  0, 4'd0,  0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 1, 4'd10, 0, 4'd9,  0, 0, 0));
    tbl.push_back(v(1, 0, 1, 1, 0, 4'd0,  1, 4'd9,  1, 1, 0));

    // Unit A: reset, then a full up sweep through the wrap.
    for (int i = 0; i < 2; i++) drive(0, 1, 0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0);
    for (int k = 1; k <= 17; k++)
      drive(0, 0, 1, 1, 0, 4'd0, 0, 4'(k % 16), k == 16, k >= 16, 0);

    // Unit A: down through zero, then clear both flags.
    drive(0, 0, 1, 0, 0, 4'd0, 0, 4'd0,  0, 1, 0);
    drive(0, 0, 1, 0, 0, 4'd0, 0, 4'd15, 1, 1, 1);
    drive(0, 0, 1, 0, 0, 4'd0, 0, 4'd14, 0, 1, 1);
    drive(0, 0, 1, 0, 0, 4'd0, 0, 4'd13, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 4'd0, 1, 4'd13, 0, 0, 0);

    foreach (tbl[i])
      drive(tbl[i].sel, tbl[i].rst, tbl[i].en, tbl[i].ud, tbl[i].ld, tbl[i].lv,
            tbl[i].clr, tbl[i].cnt, tbl[i].tc, tbl[i].ovf, tbl[i].unf);

    // Direction toggles every two cycles with enable gaps, from count 3.
    for (int s = 0; s < 2; s++) begin
      m_cnt[s] = 0; m_ovf[s] = 1'b0; m_unf[s] = 1'b0;
      model_step(s, 1, 0, 0, 0, 4'd0, 0);
      model_step(s, 0, 0, 0, 1, 4'd3, 0);
      for (int i = 0; i < 40; i++)
        model_step(s, 0, (i % 7) != 6, ((i / 2) % 2) == 0, 0, 4'd0, 0);
    end

    // Mixed random traffic on both units.
    for (int i = 0; i < 300; i++) begin
      model_step(int'($urandom_range(1, 0)),
                 $urandom_range(31, 0) == 0,
                 $urandom_range(3, 0) != 0,
                 1'($urandom_range(1, 0)),
                 $urandom_range(7, 0) == 0,
                 4'($urandom_range(15, 0)),
                 $urandom_range(9, 0) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
